// File: rtl/pwm_compare_deadtime_pkg.sv
// Shared types and defaults for the compare / dead-time PWM output stage.
//   dt_state_e   : gate FSM states (off, high on, dead time to low, low on,
//                  dead time to high)
//   gate_h/gate_l: gate level driven while the FSM sits in a given state
package pwm_compare_deadtime_pkg;

  localparam int unsigned DefWidth   = 16;
  localparam int unsigned DefDtWidth = 10;

  typedef enum logic [2:0] {
    StOff   = 3'd0,
    StHOn   = 3'd1,
    StDtToL = 3'd2,
    StLOn   = 3'd3,
    StDtToH = 3'd4
  } dt_state_e;

  // Gates are decoded from the next state, so at most one can ever be high.
  function automatic logic gate_h(dt_state_e s);
    return (s == StHOn);
  endfunction

  function automatic logic gate_l(dt_state_e s);
    return (s == StLOn);
  endfunction

endpackage

// File: rtl/pwm_compare_deadtime_if.sv
// Carrier / compare / gate bundle between the carrier generator and control
// side (master) and the compare + dead-time stage (slave).
//   enable, carrier, mask_event, compare_in, compare_wr, deadtime : master -> slave
//   compare_active, update_pending, pwm_ref, pwm_h, pwm_l          : slave -> master
interface pwm_compare_deadtime_if
  import pwm_compare_deadtime_pkg::*;
#(
  parameter int unsigned WIDTH    = DefWidth,
  parameter int unsigned DT_WIDTH = DefDtWidth
);

  logic                enable;
  logic [WIDTH-1:0]    carrier;
  logic                mask_event;
  logic [WIDTH-1:0]    compare_in;
  logic                compare_wr;
  logic [DT_WIDTH-1:0] deadtime;
  logic [WIDTH-1:0]    compare_active;
  logic                update_pending;
  logic                pwm_ref;
  logic                pwm_h;
  logic                pwm_l;

  modport master (
    output enable, carrier, mask_event, compare_in, compare_wr, deadtime,
    input  compare_active, update_pending, pwm_ref, pwm_h, pwm_l
  );

  modport slave (
    input  enable, carrier, mask_event, compare_in, compare_wr, deadtime,
    output compare_active, update_pending, pwm_ref, pwm_h, pwm_l
  );

endinterface

// File: rtl/pwm_deadtime_unit.sv
// Complementary gate FSM with programmable dead time.
//   clk, reset : clock, synchronous active-high reset
//   enable     : 0 forces both gates low and returns to StOff
//   pwm_ref    : registered raw comparison result
//   deadtime   : dead time in clk cycles, 0 = none; sampled when a gate drops
//   pwm_h/l    : registered high-side / low-side gates, never both high
module pwm_deadtime_unit
  import pwm_compare_deadtime_pkg::*;
#(
  parameter int unsigned DT_WIDTH = DefDtWidth
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                pwm_ref,
  input  logic [DT_WIDTH-1:0] deadtime,
  output logic                pwm_h,
  output logic                pwm_l
);

  localparam logic [DT_WIDTH-1:0] CntOne = DT_WIDTH'(1);

  dt_state_e           state_q, state_d;
  logic [DT_WIDTH-1:0] cnt_q, cnt_d;
  logic                h_q, l_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!enable) begin
      state_d = StOff;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StOff: begin
          state_d = pwm_ref ? StHOn : StLOn;
        end
        StHOn: begin
          if (!pwm_ref) begin
            if (deadtime == '0) begin
              state_d = StLOn;
            end else begin
              state_d = StDtToL;
              cnt_d   = deadtime;
            end
          end
        end
        StDtToL: begin
          // A reference pulse that ends inside the dead time is swallowed.
          if (pwm_ref) begin
            state_d = StHOn;
            cnt_d   = '0;
          end else if (cnt_q == CntOne) begin
            state_d = StLOn;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - CntOne;
          end
        end
        StLOn: begin
          if (pwm_ref) begin
            if (deadtime == '0) begin
              state_d = StHOn;
            end else begin
              state_d = StDtToH;
              cnt_d   = deadtime;
            end
          end
        end
        StDtToH: begin
          if (!pwm_ref) begin
            state_d = StLOn;
            cnt_d   = '0;
          end else if (cnt_q == CntOne) begin
            state_d = StHOn;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - CntOne;
          end
        end
        default: begin
          state_d = StOff;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StOff;
      cnt_q   <= '0;
      h_q     <= 1'b0;
      l_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      h_q     <= gate_h(state_d);
      l_q     <= gate_l(state_d);
    end
  end

  assign pwm_h = h_q;
  assign pwm_l = l_q;

endmodule

// File: rtl/pwm_compare_deadtime.sv
// Compare stage of the PWM output path: double-buffers the compare value
// (shadow -> active on mask_event), registers carrier < compare_active as
// pwm_ref and hands it to the dead-time unit that drives the gates.
//   clk, reset : clock, synchronous active-high reset
//   bus        : slave side of pwm_compare_deadtime_if (carrier, strobes,
//                compare value, dead time in; active compare, status, gates out)
module pwm_compare_deadtime
  import pwm_compare_deadtime_pkg::*;
#(
  parameter int unsigned WIDTH    = DefWidth,
  parameter int unsigned DT_WIDTH = DefDtWidth
) (
  input logic                   clk,
  input logic                   reset,
  pwm_compare_deadtime_if.slave bus
);

  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic [WIDTH-1:0] active_q, active_d;
  logic             pending_q, pending_d;
  logic             ref_q, ref_d;
  logic             gate_h_w, gate_l_w;

  always_comb begin
    shadow_d  = shadow_q;
    active_d  = active_q;
    pending_d = pending_q;
    if (bus.compare_wr) begin
      shadow_d  = bus.compare_in;
      pending_d = 1'b1;
    end
    // A write coinciding with the update strobe bypasses the shadow.
    if (bus.mask_event) begin
      active_d  = bus.compare_wr ? bus.compare_in : shadow_q;
      pending_d = 1'b0;
    end
    ref_d = (bus.carrier < active_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_q  <= '0;
      active_q  <= '0;
      pending_q <= 1'b0;
      ref_q     <= 1'b0;
    end else begin
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      pending_q <= pending_d;
      ref_q     <= ref_d;
    end
  end

  pwm_deadtime_unit #(
    .DT_WIDTH (DT_WIDTH)
  ) u_dt (
    .clk      (clk),
    .reset    (reset),
    .enable   (bus.enable),
    .pwm_ref  (ref_q),
    .deadtime (bus.deadtime),
    .pwm_h    (gate_h_w),
    .pwm_l    (gate_l_w)
  );

  assign bus.compare_active = active_q;
  assign bus.update_pending = pending_q;
  assign bus.pwm_ref        = ref_q;
  assign bus.pwm_h          = gate_h_w;
  assign bus.pwm_l          = gate_l_w;

endmodule

// File: tb/tb_pwm_compare_deadtime.sv
// Directed bench for pwm_compare_deadtime: triangle carrier 0..10, compare
// buffering, saturation, glitch swallowing, reset and enable handling.
module tb_pwm_compare_deadtime;
  import pwm_compare_deadtime_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad = 0;
  int   overlap = 0;

  pwm_compare_deadtime_if #(.WIDTH(16), .DT_WIDTH(10)) bus ();

  pwm_compare_deadtime #(
    .WIDTH    (16),
    .DT_WIDTH (10)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if ((bus.pwm_h & bus.pwm_l) === 1'b1) overlap++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Triangle carrier, period 10 up and 10 down.
  function automatic int tri_c(int j);
    int t;
    t = j % 20;
    return (t <= 10) ? t : 20 - t;
  endfunction

  // pwm_ref after edge j; before the run the carrier is held at 0.
  function automatic logic ref_at(int j, int cmp);
    if (j < 0) return (0 < cmp);
    return (tri_c(j) < cmp);
  endfunction

  // A gate is on after edge j when the reference held its level for dt+1 edges.
  function automatic logic win(int j, int dt, int cmp, logic lvl);
    for (int i = 0; i <= dt; i++) begin
      if (ref_at(j - 1 - i, cmp) != lvl) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic load_now(input logic [15:0] v);
    bus.compare_in = v;
    bus.compare_wr = 1'b1;
    bus.mask_event = 1'b1;
    tick();
    bus.compare_wr = 1'b0;
    bus.mask_event = 1'b0;
  endtask

  initial begin
    reset          = 1'b1;
    bus.enable     = 1'b0;
    bus.carrier    = '0;
    bus.mask_event = 1'b0;
    bus.compare_in = '0;
    bus.compare_wr = 1'b0;
    bus.deadtime   = '0;
    tick();
    tick();
    chk("rst_h", bus.pwm_h, 0);
    chk("rst_l", bus.pwm_l, 0);
    chk("rst_active", bus.compare_active, 0);
    chk("rst_pending", bus.update_pending, 0);
    chk("rst_ref", bus.pwm_ref, 0);
    reset = 1'b0;

    // 1: compare 4, no dead time
    load_now(16'd4);
    tick();
    bus.enable = 1'b1;
    for (int j = 0; j < 40; j++) begin
      bus.carrier = 16'(tri_c(j));
      tick();
      chk("t1_ref", bus.pwm_ref, ref_at(j, 4));
      chk("t1_h", bus.pwm_h, ref_at(j - 1, 4));
      chk("t1_l", bus.pwm_l, !ref_at(j - 1, 4));
    end

    // 2: same carrier, dead time 3
    bus.enable   = 1'b0;
    bus.deadtime = 10'd3;
    bus.carrier  = '0;
    tick();
    tick();
    chk("t2_off_h", bus.pwm_h, 0);
    chk("t2_off_l", bus.pwm_l, 0);
    bus.enable = 1'b1;
    for (int j = 0; j < 40; j++) begin
      bus.carrier = 16'(tri_c(j));
      tick();
      chk("t2_h", bus.pwm_h, win(j, 3, 4, 1'b1));
      chk("t2_l", bus.pwm_l, win(j, 3, 4, 1'b0));
    end

    // 3: shadow buffering
    bus.carrier    = '0;
    bus.compare_in = 16'd7;
    bus.compare_wr = 1'b1;
    tick();
    bus.compare_wr = 1'b0;
    chk("t3_hold_active", bus.compare_active, 4);
    chk("t3_pending", bus.update_pending, 1);
    tick();
    chk("t3_still_active", bus.compare_active, 4);
    bus.mask_event = 1'b1;
    tick();
    bus.mask_event = 1'b0;
    chk("t3_xfer_active", bus.compare_active, 7);
    chk("t3_xfer_pending", bus.update_pending, 0);
    load_now(16'd9);
    chk("t3_bypass_active", bus.compare_active, 9);
    chk("t3_bypass_pending", bus.update_pending, 0);

    // 4: saturation at both ends
    load_now(16'd0);
    for (int j = 0; j < 30; j++) begin
      bus.carrier = 16'(tri_c(j));
      tick();
      if (j >= 8) begin
        chk("t4_zero_h", bus.pwm_h, 0);
        chk("t4_zero_l", bus.pwm_l, 1);
      end
    end
    load_now(16'd11);
    for (int j = 0; j < 30; j++) begin
      bus.carrier = 16'(tri_c(j));
      tick();
      if (j >= 8) begin
        chk("t4_full_h", bus.pwm_h, 1);
        chk("t4_full_l", bus.pwm_l, 0);
      end
    end

    // 5: 2-cycle glitch in L_ON with dead time 3
    load_now(16'd4);
    bus.carrier = 16'd8;
    for (int j = 0; j < 8; j++) tick();
    chk("t5_pre_l", bus.pwm_l, 1);
    chk("t5_pre_h", bus.pwm_h, 0);
    bus.carrier = 16'd2;
    tick();
    chk("t5_e0_l", bus.pwm_l, 1);
    tick();
    chk("t5_e1_l", bus.pwm_l, 0);
    chk("t5_e1_h", bus.pwm_h, 0);
    bus.carrier = 16'd8;
    tick();
    chk("t5_e2_l", bus.pwm_l, 0);
    chk("t5_e2_h", bus.pwm_h, 0);
    tick();
    chk("t5_e3_l", bus.pwm_l, 1);
    chk("t5_e3_h", bus.pwm_h, 0);
    tick();
    chk("t5_e4_l", bus.pwm_l, 1);

    // 6: reset in DT_TO_H, then enable drop in H_ON
    bus.carrier = 16'd2;
    tick();
    chk("t6_a0_l", bus.pwm_l, 1);
    tick();
    chk("t6_a1_l", bus.pwm_l, 0);
    chk("t6_a1_state", dut.u_dt.state_q, StDtToH);
    reset = 1'b1;
    tick();
    chk("t6_rst_h", bus.pwm_h, 0);
    chk("t6_rst_l", bus.pwm_l, 0);
    chk("t6_rst_active", bus.compare_active, 0);
    chk("t6_rst_ref", bus.pwm_ref, 0);
    chk("t6_rst_state", dut.u_dt.state_q, StOff);
    reset = 1'b0;
    load_now(16'd4);
    chk("t6_b0_l", bus.pwm_l, 1);
    chk("t6_b0_active", bus.compare_active, 4);
    tick();
    chk("t6_b1_l", bus.pwm_l, 1);
    tick();
    chk("t6_b2_l", bus.pwm_l, 0);
    tick();
    tick();
    chk("t6_b4_h", bus.pwm_h, 0);
    tick();
    chk("t6_b5_h", bus.pwm_h, 1);
    bus.enable = 1'b0;
    tick();
    chk("t6_dis_h", bus.pwm_h, 0);
    chk("t6_dis_l", bus.pwm_l, 0);
    chk("t6_dis_state", dut.u_dt.state_q, StOff);
    bus.enable = 1'b1;
    tick();
    chk("t6_resume_h", bus.pwm_h, 1);
    chk("t6_resume_l", bus.pwm_l, 0);

    chk("no_overlap", overlap, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
